// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to APB initiator.
// One transfer outstanding at a time; a watchdog aborts ACCESS phases
// whose completer never raises pready (TIMEOUT = 0 disables it).
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0, one cycle
// ACCESS | psel=1, penable=1, waiting for pready or watchdog expiry
// RESP   | rsp_valid high, waiting for rsp_ready
module apb_cmd_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int WD_WIDTH   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN      = (TIMEOUT != 0);
  // Expiry fires in the ACCESS cycle whose increment would reach TIMEOUT,
  // so an idle completer sees exactly TIMEOUT ACCESS cycles.
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_WIDTH-1:0] WD_MAX  = WD_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [WD_WIDTH-1:0]     wd_q, wd_d;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    busy_d        = busy_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    wd_d          = wd_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? '1 : '0;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wd_d      = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pstrb_d       = '0;
          state_d       = RESP;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          pstrb_d       = '0;
          state_d       = RESP;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          cmd_ready_d   = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; cmd_ready comes out of reset already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      wd_q          <= wd_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = 3'b000;
  assign psel        = psel_q;
  assign penable     = penable_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master with an APB completer model.
module tb_apb_cmd_master;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout, busy;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            waits;   // wait states before pready; >= TO means the completer stalls
    logic [DW-1:0] rd;
    logic          err;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            n_acc;
  } bus_t;

  cmd_t comp_q[$];
  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int tests = 0;
  int fails = 0;
  int n_rsp = 0;
  bit rr_rand = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the watchdog allows TO ACCESS cycles, pready in any of them wins.
  function automatic rsp_t model_rsp(cmd_t c);
    rsp_t r;
    if (c.waits < TO) begin
      r.rdata = c.w ? '0 : c.rd;
      r.err   = c.err;
      r.to    = 1'b0;
    end else begin
      r.rdata = '0;
      r.err   = 1'b1;
      r.to    = 1'b1;
    end
    return r;
  endfunction

  function automatic bus_t model_bus(cmd_t c);
    bus_t b;
    b.w     = c.w;
    b.a     = c.a;
    b.d     = c.w ? c.d : '0;
    b.n_acc = (c.waits < TO) ? c.waits + 1 : TO;
    return b;
  endfunction

  // APB completer: answers each ACCESS phase after the configured wait states.
  initial begin : completer
    cmd_t cur;
    int   acc;
    bit   in_acc;
    in_acc = 0;
    acc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in_acc = 0;
        pready = 1'b0;
        pslverr = 1'b0;
      end else if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1;
          acc = 0;
          if (comp_q.size() > 0) cur = comp_q.pop_front();
          else begin cur.waits = NEVER; cur.rd = '0; cur.err = 1'b0; cur.w = 1'b0; end
        end else acc++;
        pready  = (acc == cur.waits);
        prdata  = pready ? cur.rd : DW'($urandom);
        pslverr = pready ? cur.err : 1'b0;
      end else begin
        in_acc = 0;
        pready = 1'b0;
        pslverr = 1'b0;
        prdata = DW'($urandom);
      end
    end
  end

  // Random rsp_ready backpressure when enabled.
  initial begin : rr_drv
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Response monitor: every cycle rsp_valid is high the fields must match the head.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response at %0t", $time);
        end else begin
          e = rsp_q[0];
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", rsp_err, e.err);
          check("rsp_timeout", rsp_timeout, e.to);
          check("cmd_ready_in_resp", cmd_ready, 0);
          if (rsp_ready) begin
            void'(rsp_q.pop_front());
            n_rsp++;
          end
        end
      end
    end
  end

  // Bus monitor: request fields at SETUP, stability and ACCESS-cycle count per transfer.
  initial begin : bus_mon
    bus_t cur;
    int   acc;
    bit   active;
    active = 0;
    acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
      end else if (psel && !penable) begin
        if (bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL bus_unexpected: got psel=1, expected idle bus at %0t", $time);
          active = 0;
        end else begin
          cur = bus_q[0];
          active = 1;
          acc = 0;
          check("setup_paddr", paddr, cur.a);
          check("setup_pwrite", pwrite, cur.w);
          check("setup_pwdata", pwdata, cur.d);
          check("setup_pstrb", pstrb, cur.w ? {SW{1'b1}} : '0);
          check("pprot", pprot, 0);
          check("busy_setup", busy, 1);
        end
      end else if (psel && penable) begin
        acc++;
        if (active) begin
          check("access_paddr", paddr, cur.a);
          check("access_pwrite", pwrite, cur.w);
          check("access_pwdata", pwdata, cur.d);
          check("access_pstrb", pstrb, cur.w ? {SW{1'b1}} : '0);
        end
      end else begin
        if (penable) check("penable_without_psel", penable, 0);
        if (active) begin
          check("access_cycles", acc, cur.n_acc);
          check("idle_pstrb", pstrb, 0);
          void'(bus_q.pop_front());
          active = 0;
        end
      end
    end
  end

  task automatic send(cmd_t c, output time t_acc);
    int guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_write = c.w;
    cmd_addr  = c.a;
    cmd_wdata = c.d;
    comp_q.push_back(c);
    rsp_q.push_back(model_rsp(c));
    bus_q.push_back(model_bus(c));
    do begin
      @(negedge clk);
      guard++;
    end while (!cmd_ready && guard < 300);
    if (!cmd_ready) check("accept_bound", 0, 1);
    @(posedge clk);
    t_acc = $time;
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    cmd_write = 1'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || busy) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_bound", (rsp_q.size() == 0 && !busy), 1);
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(logic w, logic [AW-1:0] a, logic [DW-1:0] d, int waits,
                              logic [DW-1:0] rd, logic err);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.waits = waits; c.rd = rd; c.err = err;
    return c;
  endfunction

  initial begin : main
    time t0, t1, t2;
    int  guard, n_before;
    cmd_t c;

    // Reset values.
    #12;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb", pstrb, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Zero-wait write with phase timing.
    rsp_ready = 1'b1;
    send(mk(1'b1, 15'h0010, 32'hDEADBEEF, 0, 32'h0BADF00D, 1'b0), t0);
    @(negedge clk);
    check("zw_psel", psel, 1);
    check("zw_penable_setup", penable, 0);
    check("zw_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    check("zw_penable", penable, 1);
    check("zw_pstrb", pstrb, 4'hF);
    check("zw_pwrite", pwrite, 1);
    @(negedge clk);
    check("zw_rsp_valid", rsp_valid, 1);
    check("zw_psel_drop", psel, 0);
    drain();

    // Read with 3 wait states.
    send(mk(1'b0, 15'h0124, 32'h0, 3, 32'h12345678, 1'b0), t0);
    drain();

    // Completer error with rsp_ready held low for 5 cycles.
    rsp_ready = 1'b0;
    send(mk(1'b1, 15'h0200, 32'hCAFE0001, 1, 32'h0, 1'b1), t0);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 50);
    check("err_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("err_hold_cmd_ready", cmd_ready, 0);
      check("err_hold_valid", rsp_valid, 1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Watchdog: stalled completer, then pready exactly in the last allowed cycle.
    send(mk(1'b0, 15'h0300, 32'h0, NEVER, 32'hFFFFFFFF, 1'b0), t0);
    drain();
    send(mk(1'b0, 15'h0304, 32'h0, TO - 1, 32'hA5A5A5A5, 1'b0), t0);
    drain();

    // Back-to-back throughput.
    send(mk(1'b1, 15'h0400, 32'h11111111, 0, 32'h0, 1'b0), t0);
    send(mk(1'b0, 15'h0404, 32'h0, 0, 32'h22222222, 1'b0), t1);
    send(mk(1'b1, 15'h0408, 32'h33333333, 0, 32'h0, 1'b0), t2);
    check("b2b_gap1", (t1 - t0) / 10, 4);
    check("b2b_gap2", (t2 - t1) / 10, 4);
    drain();

    // Reset in the middle of ACCESS.
    n_before = n_rsp;
    send(mk(1'b1, 15'h0500, 32'h55AA55AA, NEVER, 32'h0, 1'b0), t0);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!(psel && penable) && guard < 20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_psel", psel, 0);
    check("mid_rst_penable", penable, 0);
    check("mid_rst_paddr", paddr, 0);
    check("mid_rst_pwdata", pwdata, 0);
    check("mid_rst_pwrite", pwrite, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    comp_q.delete();
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("no_rsp_after_rst", n_rsp, n_before);
    @(posedge clk);
    #1;
    send(mk(1'b0, 15'h0508, 32'h0, 2, 32'h87654321, 1'b0), t0);
    drain();
    check("post_rst_rsp_count", n_rsp, n_before + 1);

    // Randomized traffic with backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      c = mk(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 1)),
             DW'($urandom), ($urandom_range(0, 3) == 0));
      send(c, t0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rr_rand = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("bus_q_empty", bus_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
